// File: rtl/reg_file_cmd_ctrl.sv
// reg_file_cmd_ctrl: parses AA/BB command frames from the RX byte stream into register-file writes and reads,
//   returning read data to the TX FIFO. Write: data byte -> o_rf_wr_en 1 clk. Read: address byte -> o_tx_wr_en 3 clk.
//   Backpressure: read data is held in TX_PUSH while i_tx_full; RX bytes during a read are dropped (o_err_ovr).
// Optional feature: define CMD_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle clocks (o_err_to);
//   when undefined, partial frames wait forever and o_err_to is tied low.
// Ports: i_Ref_clk/i_rst (async active-low) clock and reset; i_rx_data/i_rx_valid RX byte strobe;
//   i_rf_rd_data/i_rf_rd_valid register-file read return; i_tx_full TX FIFO full;
//   o_rf_addr/o_rf_wr_en/o_rf_rd_en/o_rf_wr_data register-file access; o_tx_data/o_tx_wr_en TX FIFO push;
//   o_busy frame in progress; o_err_cmd/o_err_ovr/o_err_to single-cycle error pulses.
module reg_file_cmd_ctrl #(
  parameter int unsigned           WIDTH_REG   = 8,
  parameter int unsigned           ADDR        = 4,
  parameter logic [WIDTH_REG-1:0]  CMD_WR      = 8'hAA,
  parameter logic [WIDTH_REG-1:0]  CMD_RD      = 8'hBB,
  parameter int unsigned           TIMEOUT_CYC = 1024
) (
  input  logic                 i_Ref_clk,
  input  logic                 i_rst,
  input  logic [WIDTH_REG-1:0] i_rx_data,
  input  logic                 i_rx_valid,
  input  logic [WIDTH_REG-1:0] i_rf_rd_data,
  input  logic                 i_rf_rd_valid,
  input  logic                 i_tx_full,
  output logic [ADDR-1:0]      o_rf_addr,
  output logic                 o_rf_wr_en,
  output logic                 o_rf_rd_en,
  output logic [WIDTH_REG-1:0] o_rf_wr_data,
  output logic [WIDTH_REG-1:0] o_tx_data,
  output logic                 o_tx_wr_en,
  output logic                 o_busy,
  output logic                 o_err_cmd,
  output logic                 o_err_ovr,
  output logic                 o_err_to
);

  // Elaboration-time parameter sanity: the address range check slices above ADDR,
  // and the timeout counter needs at least two states.
  if (ADDR >= WIDTH_REG || TIMEOUT_CYC < 2) begin : g_param_check
    $error("reg_file_cmd_ctrl: need ADDR < WIDTH_REG and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_PUSH
  } state_t;

  state_t state;

  // Address byte is legal only when every bit above the register-file address is zero.
  logic addr_ok;
  assign addr_ok = (i_rx_data[WIDTH_REG-1:ADDR] == '0);

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            in_frame;
  assign in_frame = (state == S_WR_ADDR) || (state == S_WR_DATA) || (state == S_RD_ADDR);
`else
  assign o_err_to = 1'b0;
`endif

  always_ff @(posedge i_Ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      o_busy       <= 1'b0;
      o_rf_addr    <= '0;
      o_rf_wr_en   <= 1'b0;
      o_rf_rd_en   <= 1'b0;
      o_rf_wr_data <= '0;
      o_tx_data    <= '0;
      o_tx_wr_en   <= 1'b0;
      o_err_cmd    <= 1'b0;
      o_err_ovr    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      o_err_to     <= 1'b0;
      to_cnt       <= '0;
`endif
    end else begin
      // Strobes and error pulses default low so each lasts exactly one clock.
      o_rf_wr_en <= 1'b0;
      o_rf_rd_en <= 1'b0;
      o_tx_wr_en <= 1'b0;
      o_err_cmd  <= 1'b0;
      o_err_ovr  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      o_err_to   <= 1'b0;
`endif

      unique case (state)
        S_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_WR) begin
              state  <= S_WR_ADDR;
              o_busy <= 1'b1;
            end else if (i_rx_data == CMD_RD) begin
              state  <= S_RD_ADDR;
              o_busy <= 1'b1;
            end else begin
              o_err_cmd <= 1'b1;
            end
          end
        end

        S_WR_ADDR: begin
          if (i_rx_valid) begin
            if (addr_ok) begin
              o_rf_addr <= i_rx_data[ADDR-1:0];
              state     <= S_WR_DATA;
            end else begin
              o_err_cmd <= 1'b1;
              state     <= S_IDLE;
              o_busy    <= 1'b0;
            end
          end
        end

        S_WR_DATA: begin
          // Address was latched a frame byte earlier, so it is already stable under the strobe.
          if (i_rx_valid) begin
            o_rf_wr_data <= i_rx_data;
            o_rf_wr_en   <= 1'b1;
            state        <= S_IDLE;
            o_busy       <= 1'b0;
          end
        end

        S_RD_ADDR: begin
          if (i_rx_valid) begin
            if (addr_ok) begin
              o_rf_addr  <= i_rx_data[ADDR-1:0];
              o_rf_rd_en <= 1'b1;
              state      <= S_RD_WAIT;
            end else begin
              o_err_cmd <= 1'b1;
              state     <= S_IDLE;
              o_busy    <= 1'b0;
            end
          end
        end

        S_RD_WAIT: begin
          if (i_rx_valid) o_err_ovr <= 1'b1;
          // Push is issued together with the capture when TX has room, which gives the 3-clock read latency.
          if (i_rf_rd_valid) begin
            o_tx_data  <= i_rf_rd_data;
            o_tx_wr_en <= !i_tx_full;
            state      <= S_TX_PUSH;
          end
        end

        S_TX_PUSH: begin
          if (i_rx_valid) o_err_ovr <= 1'b1;
          // A high o_tx_wr_en means the push is on the bus this cycle: the frame is done.
          if (o_tx_wr_en) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (!i_tx_full) begin
            o_tx_wr_en <= 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase

`ifdef CMD_TIMEOUT_EN
      // Placed after the case so an expiry overrides it; the case never changes state
      // in a frame-collecting state without an RX byte, so the two never compete.
      if (in_frame && !i_rx_valid) begin
        if (to_cnt == TO_MAX) begin
          o_err_to  <= 1'b1;
          state     <= S_IDLE;
          o_busy    <= 1'b0;
          o_rf_addr <= '0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb_reg_file_cmd_ctrl: bench for reg_file_cmd_ctrl with a behavioural register file and a byte-level frame model.
//   The model turns every driven RX byte into expected strobes stamped with the cycle they must appear in;
//   a negedge monitor matches every DUT strobe against that list.
module tb_reg_file_cmd_ctrl;

  localparam int          TO_CYC = 16;
  localparam logic [7:0]  CMD_WR = 8'hAA;
  localparam logic [7:0]  CMD_RD = 8'hBB;

  localparam int K_WR = 0, K_RD = 1, K_PUSH = 2, K_ECMD = 3, K_EOVR = 4, K_ETO = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rf_rd_data  = 8'h00;
  logic       rf_rd_valid = 1'b0;
  logic       tx_full;
  logic [3:0] rf_addr;
  logic       rf_wr_en, rf_rd_en;
  logic [7:0] rf_wr_data, tx_data;
  logic       tx_wr_en, busy, err_cmd, err_ovr, err_to;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  reg_file_cmd_ctrl #(
    .WIDTH_REG(8), .ADDR(4), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .i_Ref_clk    (clk),
    .i_rst        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_rf_rd_data (rf_rd_data),
    .i_rf_rd_valid(rf_rd_valid),
    .i_tx_full    (tx_full),
    .o_rf_addr    (rf_addr),
    .o_rf_wr_en   (rf_wr_en),
    .o_rf_rd_en   (rf_rd_en),
    .o_rf_wr_data (rf_wr_data),
    .o_tx_data    (tx_data),
    .o_tx_wr_en   (tx_wr_en),
    .o_busy       (busy),
    .o_err_cmd    (err_cmd),
    .o_err_ovr    (err_ovr),
    .o_err_to     (err_to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment register file: write lands one clock after the strobe, read data returns one clock after rd_en.
  logic [7:0] rf_mem [16] = '{1: 8'h0A, 2: 8'h81, 3: 8'h20, default: 8'h00};
  always @(posedge clk) begin
    rf_rd_valid <= rf_rd_en;
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_addr];
    if (rf_wr_en) rf_mem[rf_addr] <= rf_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t        exq[$];
  logic [7:0] ref_mem [16] = '{1: 8'h0A, 2: 8'h81, 3: 8'h20, default: 8'h00};
  int         m_st = 0;            // 0 opcode, 1 write addr, 2 write data, 3 read addr
  logic [3:0] m_addr = 4'h0;
  int         m_busy_until = -1;   // last cycle a read in flight drops RX bytes
  bit         hold_push = 1'b0;    // TX held full: push expectation is added by the test itself
  logic [7:0] m_hold_data = 8'h00;

  function automatic string kname(input int k);
    case (k)
      K_WR:    return "wr";
      K_RD:    return "rd";
      K_PUSH:  return "push";
      K_ECMD:  return "err_cmd";
      K_EOVR:  return "err_ovr";
      default: return "err_to";
    endcase
  endfunction

  function automatic void push_ev(input int kind, input int c, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.d = d;
    exq.push_back(e);
  endfunction

  // Byte b is sampled at the end of cycle t; its registered reaction shows in cycle t+1.
  function automatic void model_byte(input logic [7:0] b);
    int t = cyc;
    if (t <= m_busy_until) begin
      push_ev(K_EOVR, t + 1, 8'h00, 8'h00);
      return;
    end
    case (m_st)
      0: begin
        if (b == CMD_WR) m_st = 1;
        else if (b == CMD_RD) m_st = 3;
        else push_ev(K_ECMD, t + 1, 8'h00, 8'h00);
      end
      1: begin
        if (b > 8'd15) begin
          push_ev(K_ECMD, t + 1, 8'h00, 8'h00);
          m_st = 0;
        end else begin
          m_addr = b[3:0];
          m_st = 2;
        end
      end
      2: begin
        push_ev(K_WR, t + 1, {4'h0, m_addr}, b);
        ref_mem[m_addr] = b;
        m_st = 0;
      end
      default: begin
        m_st = 0;
        if (b > 8'd15) begin
          push_ev(K_ECMD, t + 1, 8'h00, 8'h00);
        end else begin
          push_ev(K_RD, t + 1, b, 8'h00);
          if (hold_push) begin
            m_hold_data  = ref_mem[b[3:0]];
            m_busy_until = 32'h7fff_ffff;
          end else begin
            push_ev(K_PUSH, t + 3, 8'h00, ref_mem[b[3:0]]);
            m_busy_until = t + 3;
          end
        end
      end
    endcase
  endfunction

  // ---------------- monitor ----------------
  task automatic observe(input int kind, input logic hi, input logic [7:0] a, input logic [7:0] d);
    int idx = -1;
    foreach (exq[i]) if (exq[i].kind == kind && exq[i].cyc == cyc) idx = i;
    chk({kname(kind), "_strobe"}, 32'(hi), 32'(idx >= 0));
    if (hi && idx >= 0) begin
      if (kind == K_WR || kind == K_RD) chk({kname(kind), "_addr"}, 32'(a), 32'(exq[idx].a));
      if (kind == K_WR || kind == K_PUSH) chk({kname(kind), "_data"}, 32'(d), 32'(exq[idx].d));
    end
    if (idx >= 0) exq.delete(idx);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      observe(K_WR, rf_wr_en, {4'h0, rf_addr}, rf_wr_data);
      observe(K_RD, rf_rd_en, {4'h0, rf_addr}, 8'h00);
      observe(K_PUSH, tx_wr_en, 8'h00, tx_data);
      observe(K_ECMD, err_cmd, 8'h00, 8'h00);
      observe(K_EOVR, err_ovr, 8'h00, 8'h00);
      observe(K_ETO, err_to, 8'h00, 8'h00);
      chk("wr_rd_exclusive", 32'(rf_wr_en & rf_rd_en), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_strobes"}, 32'({rf_wr_en, rf_rd_en, tx_wr_en}), 32'd0);
    chk({tag, "_errs"}, 32'({err_cmd, err_ovr, err_to}), 32'd0);
    chk({tag, "_latches"}, 32'({rf_addr, rf_wr_data, tx_data}), 32'd0);
  endtask

  initial begin
    int         k, t0, tf;
    logic [7:0] a, d;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_full  = 1'b0;
    #2;
    chk_reset_outputs("reset");
    idle(2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Write then read back the same register.
    send(CMD_WR); send(8'h05); send(8'h3C);
    idle(2);
    send(CMD_RD); send(8'h05);
    idle(5);
    chk("t1_idle", 32'(busy), 32'd0);

    // Reads of register-file reset values.
    send(CMD_RD); send(8'h02); idle(4);
    send(CMD_RD); send(8'h03); idle(4);

    // Unknown opcode and out-of-range address.
    send(8'h55); idle(1);
    chk("t3_idle_after_bad_op", 32'(busy), 32'd0);
    send(CMD_WR); send(8'h1F); idle(2);
    chk("t3_idle_after_bad_addr", 32'(busy), 32'd0);

    // TX full during a read: hold for 20 clocks, then one push.
    tx_full   = 1'b1;
    hold_push = 1'b1;
    send(CMD_RD); send(8'h01);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      chk("t4_busy_while_full", 32'(busy), 32'd1);
    end
    tx_full      = 1'b0;
    tf           = cyc;
    hold_push    = 1'b0;
    push_ev(K_PUSH, tf + 1, 8'h00, m_hold_data);
    m_busy_until = tf + 1;
    idle(3);
    chk("t4_idle_after_push", 32'(busy), 32'd0);

    // Byte arriving right behind a read address is dropped.
    send(CMD_RD); send(8'h04); send(8'h77);
    idle(5);
    chk("t5_idle", 32'(busy), 32'd0);

    // Back-to-back frames with no gap.
    send(CMD_WR); send(8'h07); send(8'h5A); send(CMD_RD); send(8'h07);
    idle(5);

    // Randomized frames, including bad opcodes, bad addresses and overlapping reads.
    for (int f = 0; f < 150; f++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (k < 4) begin
        send(CMD_WR); idle($urandom_range(0, 2));
        send(a);      idle($urandom_range(0, 2));
        send(d);
      end else if (k < 8) begin
        send(CMD_RD); idle($urandom_range(0, 2));
        send(a);
      end else begin
        send(d);
      end
      idle($urandom_range(0, 4));
    end
    // Drive the model (and DUT) back to idle if the stream ended mid-frame.
    idle(5);
    for (int i = 0; i < 4 && m_st != 0; i++) begin
      send(8'hFF);
      idle(5);
    end
    chk("random_idle", 32'(busy), 32'd0);

`ifdef CMD_TIMEOUT_EN
    t0 = cyc;
    send(CMD_WR);
    push_ev(K_ETO, t0 + TO_CYC + 1, 8'h00, 8'h00);
    m_st = 0;
    idle(TO_CYC + 4);
    chk("timeout_idle", 32'(busy), 32'd0);
    send(CMD_WR);
`else
    send(CMD_WR);
    idle(40);
    chk("no_timeout_still_busy", 32'(busy), 32'd1);
`endif

    // Reset while waiting for the write data byte: no write may appear.
    send(8'h05);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midframe_reset");
    exq.delete();
    m_st         = 0;
    m_busy_until = -1;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk("post_reset_idle", 32'(busy), 32'd0);
    send(8'h3C);
    idle(2);
    send(CMD_RD); send(8'h05);
    idle(6);

    chk("pending_events", 32'(exq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
